// File: rtl/gbus_wr_arbiter.sv
// gbus_wr_arbiter: round-robin write arbiter that lets one of REQ_NUM
// requesters own the global bus for a burst and forwards each accepted beat
// as a registered one-hot write to the destination core.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   cfg_max_burst        max beats per grant (0 means 256), sampled at grant
//   req_valid/req_last   per-requester beat valid and last-beat flags
//   req_ready            per-requester beat-accept strobe (combinational)
//   req_core/addr/data   per-requester destination core, address, data
//   core_almost_full     per-core backpressure
//   gbus_wen/addr/wdata  registered one-hot bus write
//   grant_id, busy       current owner and burst-active flag
//   perf_beats, perf_stall  saturating counters, present only when
//                           GBUS_ARB_PERF_EN is defined
module gbus_wr_arbiter #(
   parameter int unsigned REQ_NUM   = 4,
   parameter int unsigned CORE_NUM  = 8,
   parameter int unsigned GBUS_DATA = 64,
   parameter int unsigned GBUS_ADDR = 12
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic [7:0]                            cfg_max_burst,
   input  logic [REQ_NUM-1:0]                    req_valid,
   input  logic [REQ_NUM-1:0]                    req_last,
   output logic [REQ_NUM-1:0]                    req_ready,
   input  logic [REQ_NUM*$clog2(CORE_NUM)-1:0]   req_core,
   input  logic [REQ_NUM*GBUS_ADDR-1:0]          req_addr,
   input  logic [REQ_NUM*GBUS_DATA-1:0]          req_data,
   input  logic [CORE_NUM-1:0]                   core_almost_full,
   output logic [CORE_NUM-1:0]                   gbus_wen,
   output logic [GBUS_ADDR-1:0]                  gbus_addr,
   output logic [GBUS_DATA-1:0]                  gbus_wdata,
   output logic [$clog2(REQ_NUM)-1:0]            grant_id,
   output logic                                  busy
`ifdef GBUS_ARB_PERF_EN
   ,
   output logic [REQ_NUM*32-1:0]                 perf_beats,
   output logic [31:0]                           perf_stall
`endif
);

   localparam int unsigned CW  = $clog2(CORE_NUM);
   localparam int unsigned GW  = $clog2(REQ_NUM);
   localparam int unsigned GW1 = GW + 1;
   localparam int unsigned BW  = 9;

   typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         rr_q, rr_d;
   logic [GW-1:0]         grant_d;
   logic [BW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         max_q, max_d;
   logic                  busy_d;
   logic [CORE_NUM-1:0]   wen_d;
   logic [GBUS_ADDR-1:0]  addr_d;
   logic [GBUS_DATA-1:0]  data_d;

   logic                  own_valid, own_last, own_ok, own_af;
   logic [CW-1:0]         own_core;
   logic [CORE_NUM-1:0]   own_onehot;
   logic [GBUS_ADDR-1:0]  own_addr;
   logic [GBUS_DATA-1:0]  own_data;
   logic                  accept;

   logic [REQ_NUM-1:0]    rot;
   logic [GW-1:0]         off;
   logic [GW:0]           sum;
   logic [GW-1:0]         pick;

   // Mux out the current owner's request fields and decode its core.
   always_comb begin
      own_valid  = 1'b0;
      own_last   = 1'b0;
      own_core   = '0;
      own_addr   = '0;
      own_data   = '0;
      own_ok     = 1'b0;
      own_af     = 1'b0;
      own_onehot = '0;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (GW'(i) == grant_id) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_core  = req_core[i*CW +: CW];
            own_addr  = req_addr[i*GBUS_ADDR +: GBUS_ADDR];
            own_data  = req_data[i*GBUS_DATA +: GBUS_DATA];
         end
      end
      // An out-of-range core matches no entry, so own_ok stays low.
      for (int c = 0; c < CORE_NUM; c++) begin
         if (CW'(c) == own_core) begin
            own_ok        = 1'b1;
            own_af        = core_almost_full[c];
            own_onehot[c] = 1'b1;
         end
      end
   end

   // Round-robin pick: rotate valids so rr_q sits at bit 0, take lowest set bit.
   always_comb begin
      rot = REQ_NUM'({req_valid, req_valid} >> rr_q);
      off = '0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (rot[k]) off = GW'(k);
      end
      sum = {1'b0, rr_q} + {1'b0, off};
      if (sum >= GW1'(REQ_NUM)) sum = sum - GW1'(REQ_NUM);
      pick = sum[GW-1:0];
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      grant_d   = grant_id;
      cnt_d     = cnt_q;
      max_d     = max_q;
      busy_d    = busy;
      wen_d     = '0;
      addr_d    = gbus_addr;
      data_d    = gbus_wdata;
      req_ready = '0;
      accept    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               max_d   = (cfg_max_burst == 8'd0) ? 9'd256 : {1'b0, cfg_max_burst};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            accept = own_valid & own_ok & ~own_af;
            for (int i = 0; i < REQ_NUM; i++) begin
               req_ready[i] = accept && (GW'(i) == grant_id);
            end
            if (accept) begin
               wen_d  = own_onehot;
               addr_d = own_addr;
               data_d = own_data;
               cnt_d  = cnt_q + 9'd1;
               if (own_last || (cnt_d == max_q)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  cnt_d   = '0;
                  rr_d    = (grant_id == GW'(REQ_NUM - 1)) ? '0 : grant_id + GW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         rr_q       <= '0;
         cnt_q      <= '0;
         max_q      <= '0;
         grant_id   <= '0;
         busy       <= 1'b0;
         gbus_wen   <= '0;
         gbus_addr  <= '0;
         gbus_wdata <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         max_q      <= max_d;
         grant_id   <= grant_d;
         busy       <= busy_d;
         gbus_wen   <= wen_d;
         gbus_addr  <= addr_d;
         gbus_wdata <= data_d;
      end
   end

`ifdef GBUS_ARB_PERF_EN
   logic stall;
   assign stall = (state_q == S_BURST) & own_valid & own_ok & own_af;

   // Saturating per-requester beat counters and owner stall counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else begin
         for (int i = 0; i < REQ_NUM; i++) begin
            if (req_ready[i] && (perf_beats[i*32 +: 32] != 32'hFFFF_FFFF)) begin
               perf_beats[i*32 +: 32] <= perf_beats[i*32 +: 32] + 32'd1;
            end
         end
         if (stall && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gbus_wr_arbiter.sv
// tb_gbus_wr_arbiter: scoreboard bench for gbus_wr_arbiter. Requester
// queues feed the DUT, hand-ordered expected bus writes go to a scoreboard
// queue, and a monitor checks every bus write and its one-cycle latency.
// Define GBUS_ARB_PERF_EN to also check the performance counters.
module tb_gbus_wr_arbiter;
   localparam int unsigned REQ_NUM   = 4;
   localparam int unsigned CORE_NUM  = 8;
   localparam int unsigned GBUS_DATA = 64;
   localparam int unsigned GBUS_ADDR = 12;
   localparam int unsigned CW        = 3;

   typedef struct packed {
      logic [CW-1:0]        core;
      logic [GBUS_ADDR-1:0] addr;
      logic [GBUS_DATA-1:0] data;
      logic                 last;
   } beat_t;

   typedef struct packed {
      logic [CORE_NUM-1:0]  wen;
      logic [GBUS_ADDR-1:0] addr;
      logic [GBUS_DATA-1:0] data;
   } exp_t;

   logic                          clk;
   logic                          rstn;
   logic [7:0]                    cfg_max_burst;
   logic [REQ_NUM-1:0]            req_valid;
   logic [REQ_NUM-1:0]            req_last;
   logic [REQ_NUM-1:0]            req_ready;
   logic [REQ_NUM*CW-1:0]         req_core;
   logic [REQ_NUM*GBUS_ADDR-1:0]  req_addr;
   logic [REQ_NUM*GBUS_DATA-1:0]  req_data;
   logic [CORE_NUM-1:0]           core_almost_full;
   logic [CORE_NUM-1:0]           gbus_wen;
   logic [GBUS_ADDR-1:0]          gbus_addr;
   logic [GBUS_DATA-1:0]          gbus_wdata;
   logic [1:0]                    grant_id;
   logic                          busy;
`ifdef GBUS_ARB_PERF_EN
   logic [REQ_NUM*32-1:0]         perf_beats;
   logic [31:0]                   perf_stall;
`endif

   beat_t rq [REQ_NUM][$];
   exp_t  exp_q [$];
   int    acc_q [$];
   int    cyc;
   int    compared;
   int    mism;

   gbus_wr_arbiter #(
      .REQ_NUM(REQ_NUM), .CORE_NUM(CORE_NUM),
      .GBUS_DATA(GBUS_DATA), .GBUS_ADDR(GBUS_ADDR)
   ) dut (
      .clk(clk), .rstn(rstn), .cfg_max_burst(cfg_max_burst),
      .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
      .req_core(req_core), .req_addr(req_addr), .req_data(req_data),
      .core_almost_full(core_almost_full),
      .gbus_wen(gbus_wen), .gbus_addr(gbus_addr), .gbus_wdata(gbus_wdata),
      .grant_id(grant_id), .busy(busy)
`ifdef GBUS_ARB_PERF_EN
      , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [GBUS_ADDR-1:0] mk_addr(input int r, input int b);
      return GBUS_ADDR'(r * 256 + b);
   endfunction

   function automatic logic [GBUS_DATA-1:0] mk_data(input int r, input int b);
      return 64'hD000_0000_0000_0000 | 64'(r * 256 + b);
   endfunction

   task automatic add_beat(input int r, input int core, input int b, input logic last);
      beat_t x;
      x.core = CW'(core);
      x.addr = mk_addr(r, b);
      x.data = mk_data(r, b);
      x.last = last;
      rq[r].push_back(x);
   endtask

   task automatic expect_beat(input int r, input int core, input int b);
      exp_t e;
      e.wen  = CORE_NUM'(1) << core;
      e.addr = mk_addr(r, b);
      e.data = mk_data(r, b);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mism++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Presents queue heads at negedge; records acceptances for the latency check.
   task automatic drive_loop();
      beat_t b;
      forever begin
         @(negedge clk);
         for (int i = 0; i < REQ_NUM; i++) begin
            if (rq[i].size() > 0) begin
               b = rq[i][0];
               req_valid[i] = 1'b1;
               req_last[i]  = b.last;
               req_core[i*CW +: CW] = b.core;
               req_addr[i*GBUS_ADDR +: GBUS_ADDR] = b.addr;
               req_data[i*GBUS_DATA +: GBUS_DATA] = b.data;
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
         #1;
         for (int i = 0; i < REQ_NUM; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               b = rq[i].pop_front();
               acc_q.push_back(cyc + 1);
            end
         end
      end
   endtask

   // Checks every bus write against the scoreboard and its acceptance cycle.
   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (gbus_wen != '0) begin
            compared++;
            if (exp_q.size() == 0) begin
               mism++;
               $display("FAIL unexpected_write actual wen=%b addr=%h data=%h required no write",
                        gbus_wen, gbus_addr, gbus_wdata);
            end else begin
               e = exp_q.pop_front();
               if (gbus_wen !== e.wen || gbus_addr !== e.addr || gbus_wdata !== e.data) begin
                  mism++;
                  $display("FAIL bus_beat actual wen=%b addr=%h data=%h required wen=%b addr=%h data=%h",
                           gbus_wen, gbus_addr, gbus_wdata, e.wen, e.addr, e.data);
               end
            end
            compared++;
            if (acc_q.size() == 0 || acc_q[0] != cyc) begin
               mism++;
               $display("FAIL write_latency actual cycle=%0d required cycle=%0d",
                        cyc, (acc_q.size() == 0) ? -1 : acc_q[0]);
            end
            if (acc_q.size() > 0) void'(acc_q.pop_front());
         end else if (acc_q.size() > 0 && acc_q[0] == cyc) begin
            compared++;
            mism++;
            $display("FAIL missing_write actual wen=0 required write at cycle %0d", cyc);
            void'(acc_q.pop_front());
         end
      end
   endtask

   function automatic bit all_empty();
      bit e = (exp_q.size() == 0);
      for (int i = 0; i < REQ_NUM; i++) if (rq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #2;
         if (all_empty()) begin
            done = 1'b1;
            break;
         end
      end
      chk({name, "_drain"}, 64'(done), 64'd1);
      chk({name, "_busy_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic wait_size(input int r, input int n, input string name);
      bit done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #2;
         if (rq[r].size() == n) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic wait_busy(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #2;
         if (busy) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 64'(done), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gbus_wen"},   64'(gbus_wen),   64'd0);
      chk({tag, "_gbus_addr"},  64'(gbus_addr),  64'd0);
      chk({tag, "_gbus_wdata"}, gbus_wdata,      64'd0);
      chk({tag, "_busy"},       64'(busy),       64'd0);
      chk({tag, "_grant_id"},   64'(grant_id),   64'd0);
      chk({tag, "_req_ready"},  64'(req_ready),  64'd0);
   endtask

   initial begin
      compared         = 0;
      mism             = 0;
      rstn             = 1'b0;
      cfg_max_burst    = 8'd0;
      req_valid        = '0;
      req_last         = '0;
      req_core         = '0;
      req_addr         = '0;
      req_data         = '0;
      core_almost_full = '0;

      fork
         drive_loop();
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("por");
      #1 rstn = 1'b1;

      // Three requesters with single-beat bursts: order 0,1,3,0,1,3.
      for (int b = 0; b < 2; b++) begin
         add_beat(0, 0, b, 1'b1);
         add_beat(1, 1, b, 1'b1);
         add_beat(3, 3, b, 1'b1);
      end
      for (int b = 0; b < 2; b++) begin
         expect_beat(0, 0, b);
         expect_beat(1, 1, b);
         expect_beat(3, 3, b);
      end
      wait_drain("rr_order");

      // Requester 2 alone: 3 beats to core 5, last on beat 3.
      for (int b = 0; b < 3; b++) begin
         add_beat(2, 5, b, 1'(b == 2));
         expect_beat(2, 5, b);
      end
      wait_busy("solo_busy_rise");
      chk("solo_grant_id", 64'(grant_id), 64'd2);
      wait_drain("solo");

      // Max burst 4: requester 0 is cut after 4 beats, requester 1 goes, 0 resumes.
      cfg_max_burst = 8'd4;
      for (int b = 0; b < 10; b++) add_beat(0, 0, b, 1'(b == 9));
      for (int b = 0; b < 2; b++) add_beat(1, 1, b, 1'(b == 1));
      for (int b = 0; b < 4; b++) expect_beat(0, 0, b);
      for (int b = 0; b < 2; b++) expect_beat(1, 1, b);
      for (int b = 4; b < 10; b++) expect_beat(0, 0, b);
      wait_drain("max_burst");

      // Core 5 almost-full for 5 cycles after beat 2 of 6.
      cfg_max_burst = 8'd0;
      for (int b = 0; b < 6; b++) begin
         add_beat(2, 5, b, 1'(b == 5));
         expect_beat(2, 5, b);
      end
      wait_size(2, 4, "stall_reach_beat2");
      core_almost_full[5] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #2;
         chk("stall_req_ready", 64'(req_ready), 64'd0);
         chk("stall_busy", 64'(busy), 64'd1);
         @(posedge clk);
         #2;
         chk("stall_gbus_wen", 64'(gbus_wen), 64'd0);
      end
      core_almost_full[5] = 1'b0;
      wait_drain("stall");
`ifdef GBUS_ARB_PERF_EN
      chk("perf_stall", 64'(perf_stall), 64'd5);
      chk("perf_beats0", 64'(perf_beats[0*32 +: 32]), 64'd12);
      chk("perf_beats1", 64'(perf_beats[1*32 +: 32]), 64'd4);
      chk("perf_beats2", 64'(perf_beats[2*32 +: 32]), 64'd9);
      chk("perf_beats3", 64'(perf_beats[3*32 +: 32]), 64'd2);
`endif

      // Reset during beat 2 of 4, then requester 0 must win over requester 3.
      for (int b = 0; b < 4; b++) begin
         add_beat(2, 5, b, 1'(b == 3));
         expect_beat(2, 5, b);
      end
      wait_size(2, 2, "rst_reach_beat2");
      #1 rstn = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) rq[i].delete();
      exp_q.delete();
      acc_q.delete();
      #1;
      chk_reset_outputs("midrst");
`ifdef GBUS_ARB_PERF_EN
      chk("midrst_perf_stall", 64'(perf_stall), 64'd0);
`endif
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      add_beat(3, 3, 0, 1'b1);
      add_beat(0, 0, 0, 1'b1);
      expect_beat(0, 0, 0);
      expect_beat(3, 3, 0);
      wait_drain("post_rst");

      repeat (3) @(posedge clk);
      #2;
      chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
